fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter STACK_DEPTH, default 8, SHALL set the number of call-stack entries.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc  input  16  program-counter value; instruction index k = pc[15:1].
REQ-005 execute_flag  input  1  phase: 0 = fetch cycle, 1 = execute cycle.
REQ-006 rom_addr  output  15  program-memory address; SHALL equal pc[15:1] combinationally.
REQ-007 rom_data  input  16  synchronous-ROM word; valid in the cycle after rom_addr is presented.
REQ-008 cond_zero  input  1  zero flag from the datapath, used by JZ.
REQ-009 load_enable  output  1  registered one-cycle request to reload the program counter.
REQ-010 load_addr  output  16  registered target instruction index; the program counter applies the <<1.
REQ-011 op_valid  output  1  registered one-cycle pulse: datapath opcode issued.
REQ-012 op_code  output  4  registered opcode of the issued instruction.
REQ-013 op_arg  output  12  registered operand of the issued instruction.
REQ-014 halted  output  1  sticky: HALT executed or stack error.
REQ-015 stack_err  output  1  sticky: call-stack overflow or underflow.

Function
REQ-016 Instruction word format SHALL be [15:12] opcode, [11:0] arg.
REQ-017 Opcodes SHALL be: 0 NOP, 1 JMP, 2 JZ, 3 CALL, 4 RET, 15 HALT; 5-14 are datapath ops.
REQ-018 The block SHALL decode rom_data only on a clock edge ending a cycle with execute_flag=1; fetch-cycle edges SHALL clear load_enable and op_valid and change no other state.
REQ-019 All decode outputs SHALL be registered: a single-cycle pulse in the cycle after the execute cycle. Timing: fetch k, execute k, pulse.
REQ-020 Datapath op: op_valid=1, op_code/op_arg from the word; load_enable=0.
REQ-021 NOP: no pulse on any output.
REQ-022 JMP: load_enable=1, load_addr={4'b0,arg}.
REQ-023 JZ: cond_zero is sampled at the execute-cycle edge; if 1, act as JMP; if 0, act as NOP.
REQ-024 CALL: push (k+1) mod 2^15 onto the call stack, then act as JMP.
REQ-025 RET: pop the top entry; load_enable=1, load_addr={1'b0,popped}.
REQ-026 CALL with the stack full SHALL push nothing and jump nowhere; it SHALL set stack_err=1 and halted=1.
REQ-027 RET with the stack empty SHALL pop nothing; it SHALL set stack_err=1 and halted=1.
REQ-028 State machine RUN -> HALTED on HALT or on a stack error; HALTED is left only by reset.
REQ-029 Entering HALTED SHALL latch halt_addr: k for HALT, or k of the faulting CALL/RET.
REQ-030 In HALTED, every execute-cycle edge SHALL produce load_enable=1, load_addr={1'b0,halt_addr}, and op_valid=0.
REQ-031 The instruction fetched in a pulse cycle is discarded by the program-counter reload, so no flush logic is required.
REQ-032 The stack SHALL be a LIFO. Push and pop never coincide. The count SHALL range 0..STACK_DEPTH.

Reset
REQ-033 Reset SHALL force the following: state RUN; stack count 0; load_enable=0; load_addr=0; op_valid=0; op_code=0; op_arg=0; halted=0; stack_err=0; halt_addr=0.
REQ-034 Reset asserted mid-instruction SHALL discard the pending decode; the first execute cycle after release decodes normally.

Structure
REQ-035 A shared package small_isa_pkg SHALL hold: the opcode enum, the INSTR_W=16, OPC_W=4 and ARG_W=12 constants, and the STACK_DEPTH default.
REQ-036 The call stack SHALL be a sub-module call_stack with push, pop, din, dout, full and empty; its storage is not reset, only its count.

Verification
REQ-037 Word 0x5123 at k=0 -> one cycle after the execute cycle: op_valid=1, op_code=5, op_arg=0x123, load_enable=0.
REQ-038 JZ 0x2040 with cond_zero=1 -> load_enable=1, load_addr=0x0040. Repeat with cond_zero=0 -> no pulse.
REQ-039 CALL 0x3100 at k=7, then RET at k=0x100 -> load_addr=0x0100, then load_addr=0x0008.
REQ-040 Nine nested CALLs (depth 8) -> the 9th sets stack_err=1 and halted=1; the PC then loops on that index.
REQ-041 RET on empty stack at k=3 -> stack_err=1, halted=1, load_addr=0x0003 every instruction slot.
REQ-042 HALT at k=0x20, then reset pulse mid-fetch -> halted=0, all outputs 0, and decode resumes from k=0.

Source files
------------

// File: rtl/small_isa_pkg.sv
// Shared definitions for the small ISA: word layout, opcodes, control states.
package small_isa_pkg;

    localparam int INSTR_W             = 16;
    localparam int OPC_W               = 4;
    localparam int ARG_W               = 12;
    localparam int ADDR_W              = 15;
    localparam int STACK_DEPTH_DEFAULT = 8;

    // Values 5..14 are not listed: they are datapath ops passed through unchanged.
    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'd0,
        OP_JMP  = 4'd1,
        OP_JZ   = 4'd2,
        OP_CALL = 4'd3,
        OP_RET  = 4'd4,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } run_state_e;

endpackage

// File: rtl/call_stack.sv
// LIFO of return indices; only the occupancy count is reset, storage is not.
module call_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] top_w;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign top_w = count_q - 1'b1;
    assign dout  = mem_q[top_w[IDX_W-1:0]];

    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop && !empty) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[count_q[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// Decodes one ROM word per execute cycle into a registered one-cycle pulse:
// PC reload (JMP/JZ/CALL/RET/halt loop) or a datapath opcode issue.
module fetch_decode
    import small_isa_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        pc,
    input  logic               execute_flag,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               cond_zero,
    output logic               load_enable,
    output logic [15:0]        load_addr,
    output logic               op_valid,
    output logic [OPC_W-1:0]   op_code,
    output logic [ARG_W-1:0]   op_arg,
    output logic               halted,
    output logic               stack_err,
    output run_state_e         dbg_state
);

    run_state_e          state_q;
    logic                load_enable_q;
    logic [15:0]         load_addr_q;
    logic                op_valid_q;
    logic [OPC_W-1:0]    op_code_q;
    logic [ARG_W-1:0]    op_arg_q;
    logic                halted_q;
    logic                stack_err_q;
    logic [ADDR_W-1:0]   halt_addr_q;

    opcode_e             opc_w;
    logic [ARG_W-1:0]    arg_w;
    logic [ADDR_W-1:0]   k_w;
    logic [ADDR_W-1:0]   ret_idx_w;
    logic [ADDR_W-1:0]   pop_data_w;
    logic                exec_run_w;
    logic                push_w;
    logic                pop_w;
    logic                full_w;
    logic                empty_w;
    logic                unused_pc0;

    assign rom_addr   = pc[15:1];
    assign unused_pc0 = pc[0];
    assign k_w        = pc[15:1];
    assign opc_w      = opcode_e'(rom_data[INSTR_W-1:ARG_W]);
    assign arg_w      = rom_data[ARG_W-1:0];
    assign ret_idx_w  = k_w + 1'b1;

    // Stack traffic only happens on execute edges while running; faults never touch it.
    assign exec_run_w = execute_flag && (state_q == ST_RUN);
    assign push_w     = exec_run_w && (opc_w == OP_CALL) && !full_w;
    assign pop_w      = exec_run_w && (opc_w == OP_RET) && !empty_w;

    call_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_w),
        .pop   (pop_w),
        .din   (ret_idx_w),
        .dout  (pop_data_w),
        .full  (full_w),
        .empty (empty_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            load_enable_q <= 1'b0;
            load_addr_q   <= '0;
            op_valid_q    <= 1'b0;
            op_code_q     <= '0;
            op_arg_q      <= '0;
            halted_q      <= 1'b0;
            stack_err_q   <= 1'b0;
            halt_addr_q   <= '0;
        end else begin
            load_enable_q <= 1'b0;
            op_valid_q    <= 1'b0;
            if (execute_flag) begin
                if (state_q == ST_HALTED) begin
                    // Keep pinning the PC on the faulting/halting instruction.
                    load_enable_q <= 1'b1;
                    load_addr_q   <= {1'b0, halt_addr_q};
                end else begin
                    case (opc_w)
                        OP_NOP: ;
                        OP_JMP: begin
                            load_enable_q <= 1'b1;
                            load_addr_q   <= {4'b0, arg_w};
                        end
                        OP_JZ: begin
                            if (cond_zero) begin
                                load_enable_q <= 1'b1;
                                load_addr_q   <= {4'b0, arg_w};
                            end
                        end
                        OP_CALL: begin
                            if (full_w) begin
                                state_q     <= ST_HALTED;
                                halted_q    <= 1'b1;
                                stack_err_q <= 1'b1;
                                halt_addr_q <= k_w;
                            end else begin
                                load_enable_q <= 1'b1;
                                load_addr_q   <= {4'b0, arg_w};
                            end
                        end
                        OP_RET: begin
                            if (empty_w) begin
                                state_q     <= ST_HALTED;
                                halted_q    <= 1'b1;
                                stack_err_q <= 1'b1;
                                halt_addr_q <= k_w;
                            end else begin
                                load_enable_q <= 1'b1;
                                load_addr_q   <= {1'b0, pop_data_w};
                            end
                        end
                        OP_HALT: begin
                            state_q     <= ST_HALTED;
                            halted_q    <= 1'b1;
                            halt_addr_q <= k_w;
                        end
                        default: begin
                            op_valid_q <= 1'b1;
                            op_code_q  <= rom_data[INSTR_W-1:ARG_W];
                            op_arg_q   <= arg_w;
                        end
                    endcase
                end
            end
        end
    end

    assign load_enable = load_enable_q;
    assign load_addr   = load_addr_q;
    assign op_valid    = op_valid_q;
    assign op_code     = op_code_q;
    assign op_arg      = op_arg_q;
    assign halted      = halted_q;
    assign stack_err   = stack_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: instruction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized instruction streams.
module tb_fetch_decode;
  import small_isa_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        execute_flag;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic        cond_zero;
  logic        load_enable;
  logic [15:0] load_addr;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [11:0] op_arg;
  logic        halted;
  logic        stack_err;
  run_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  logic [15:0] rom_mem [0:32767];

  fetch_decode #(.STACK_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .execute_flag (execute_flag),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .cond_zero    (cond_zero),
    .load_enable  (load_enable),
    .load_addr    (load_addr),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_arg       (op_arg),
    .halted       (halted),
    .stack_err    (stack_err),
    .dbg_state    (dbg_state)
  );

  // clock / synchronous ROM
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // reference model: one step per execute edge
  logic        m_le, m_ov, m_halted, m_err;
  logic [15:0] m_la;
  logic [3:0]  m_opc;
  logic [11:0] m_arg;
  int          m_haddr;
  int          stk[$];

  task automatic model_clear();
    m_le = 0; m_ov = 0; m_halted = 0; m_err = 0;
    m_la = 0; m_opc = 0; m_arg = 0; m_haddr = 0;
    stk.delete();
  endtask

  task automatic model_fault(input int k, input bit is_err);
    m_halted = 1;
    if (is_err) m_err = 1;
    m_haddr = k;
  endtask

  task automatic model_step();
    int k, op, a;
    logic [15:0] w;
    m_le = 0;
    m_ov = 0;
    if (execute_flag) begin
      k  = int'(pc) / 2;
      w  = rom_mem[k];
      op = int'(w) / 4096;
      a  = int'(w) % 4096;
      if (m_halted) begin
        m_le = 1; m_la = 16'(m_haddr);
      end else if (op == 0) begin
      end else if (op == 1 || (op == 2 && cond_zero)) begin
        m_le = 1; m_la = 16'(a);
      end else if (op == 2) begin
      end else if (op == 3) begin
        if (stk.size() == DEPTH) model_fault(k, 1);
        else begin
          stk.push_back((k + 1) % 32768);
          m_le = 1; m_la = 16'(a);
        end
      end else if (op == 4) begin
        if (stk.size() == 0) model_fault(k, 1);
        else begin
          m_le = 1; m_la = 16'(stk.pop_back());
        end
      end else if (op == 15) begin
        model_fault(k, 0);
      end else begin
        m_ov = 1; m_opc = 4'(op); m_arg = 12'(a);
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started && !reset) begin
        chk("rom_addr", 32'(rom_addr), 32'(pc[15:1]));
        chk("load_enable", 32'(load_enable), 32'(m_le));
        chk("op_valid", 32'(op_valid), 32'(m_ov));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("stack_err", 32'(stack_err), 32'(m_err));
        chk("dbg_state", 32'(dbg_state == ST_HALTED), 32'(m_halted));
        if (m_le) chk("load_addr", 32'(load_addr), 32'(m_la));
        if (m_ov) begin
          chk("op_code", 32'(op_code), 32'(m_opc));
          chk("op_arg", 32'(op_arg), 32'(m_arg));
        end
      end
    end
  end

  // driver tasks
  task automatic exec(input logic [14:0] k, input logic [15:0] w, input logic cz);
    @(posedge clk);
    #2;
    rom_mem[k]   = w;
    pc           = {k, 1'b0};
    execute_flag = 1'b0;
    cond_zero    = 1'($urandom_range(0, 1));
    @(posedge clk);
    #2;
    execute_flag = 1'b1;
    cond_zero    = cz;
  endtask

  task automatic expect_pulse(input string name, input logic le, input logic [15:0] la,
                              input logic ov, input logic [3:0] opc, input logic [11:0] arg,
                              input logic h, input logic e);
    @(posedge clk);
    #2;
    execute_flag = 1'b0;
    #3;
    chk({name, ".le"}, 32'(load_enable), 32'(le));
    chk({name, ".ov"}, 32'(op_valid), 32'(ov));
    if (le) chk({name, ".la"}, 32'(load_addr), 32'(la));
    if (ov) begin
      chk({name, ".opc"}, 32'(op_code), 32'(opc));
      chk({name, ".arg"}, 32'(op_arg), 32'(arg));
    end
    chk({name, ".halted"}, 32'(halted), 32'(h));
    chk({name, ".err"}, 32'(stack_err), 32'(e));
  endtask

  task automatic check_reset_values(input string name);
    chk({name, ".le"}, 32'(load_enable), 32'h0);
    chk({name, ".la"}, 32'(load_addr), 32'h0);
    chk({name, ".ov"}, 32'(op_valid), 32'h0);
    chk({name, ".opc"}, 32'(op_code), 32'h0);
    chk({name, ".arg"}, 32'(op_arg), 32'h0);
    chk({name, ".halted"}, 32'(halted), 32'h0);
    chk({name, ".err"}, 32'(stack_err), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    execute_flag = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    logic [11:0] a;
    r = $urandom_range(0, 99);
    a = 12'($urandom_range(0, 4095));
    if (r < 10)      return {4'd0, a};
    else if (r < 20) return {4'd1, a};
    else if (r < 32) return {4'd2, a};
    else if (r < 50) return {4'd3, a};
    else if (r < 66) return {4'd4, a};
    else if (r < 69) return {4'd15, a};
    else             return {4'($urandom_range(5, 14)), a};
  endfunction

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    for (int i = 0; i < 32768; i++) rom_mem[i] = 16'h0000;
    reset = 1'b1; pc = 16'h0; execute_flag = 1'b0; cond_zero = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_values("reset");
    reset   = 1'b0;
    started = 1;

    // datapath issue
    exec(15'd0, 16'h5123, 1'b0);
    expect_pulse("dp_issue", 0, 16'h0, 1, 4'h5, 12'h123, 0, 0);

    // JZ taken / not taken
    exec(15'd1, 16'h2040, 1'b1);
    expect_pulse("jz_taken", 1, 16'h0040, 0, 4'h0, 12'h0, 0, 0);
    exec(15'd1, 16'h2040, 1'b0);
    expect_pulse("jz_not", 0, 16'h0, 0, 4'h0, 12'h0, 0, 0);

    // CALL / RET pair
    exec(15'd7, 16'h3100, 1'b0);
    expect_pulse("call", 1, 16'h0100, 0, 4'h0, 12'h0, 0, 0);
    exec(15'h100, 16'h4000, 1'b0);
    expect_pulse("ret", 1, 16'h0008, 0, 4'h0, 12'h0, 0, 0);

    // RET on empty stack
    exec(15'd3, 16'h4000, 1'b0);
    expect_pulse("ret_empty", 0, 16'h0, 0, 4'h0, 12'h0, 1, 1);
    exec(15'd4, 16'h1555, 1'b0);
    expect_pulse("ret_empty_loop1", 1, 16'h0003, 0, 4'h0, 12'h0, 1, 1);
    exec(15'd3, 16'h4000, 1'b0);
    expect_pulse("ret_empty_loop2", 1, 16'h0003, 0, 4'h0, 12'h0, 1, 1);
    do_reset();

    // nine nested CALLs overflow an 8-deep stack
    for (int i = 0; i < 8; i++) begin
      exec(15'(16'h40 + i), 16'(16'h3041 + i), 1'b0);
      expect_pulse("nest_call", 1, 16'(16'h41 + i), 0, 4'h0, 12'h0, 0, 0);
    end
    exec(15'h48, 16'h3049, 1'b0);
    expect_pulse("call_full", 0, 16'h0, 0, 4'h0, 12'h0, 1, 1);
    exec(15'h49, 16'h0000, 1'b0);
    expect_pulse("call_full_loop", 1, 16'h0048, 0, 4'h0, 12'h0, 1, 1);
    do_reset();

    // return index wraps at the top of the address space
    exec(15'h7FFF, 16'h3005, 1'b0);
    expect_pulse("call_wrap", 1, 16'h0005, 0, 4'h0, 12'h0, 0, 0);
    exec(15'd5, 16'h4000, 1'b0);
    expect_pulse("ret_wrap", 1, 16'h0000, 0, 4'h0, 12'h0, 0, 0);

    // HALT, then reset asserted in the middle of a fetch cycle
    exec(15'h20, 16'hF000, 1'b0);
    expect_pulse("halt", 0, 16'h0, 0, 4'h0, 12'h0, 1, 0);
    exec(15'h21, 16'h5777, 1'b0);
    expect_pulse("halt_loop", 1, 16'h0020, 0, 4'h0, 12'h0, 1, 0);
    @(posedge clk);
    #2;
    pc = 16'h0042; execute_flag = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    reset = 1'b0;
    exec(15'd0, 16'h5123, 1'b0);
    expect_pulse("resume", 0, 16'h0, 1, 4'h5, 12'h123, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 500; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 59) == 0) begin
        @(posedge clk);
        #2;
        pc = 16'($urandom_range(0, 65535)); execute_flag = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      exec(15'($urandom_range(0, 32767)), rand_word(), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #2;
    execute_flag = 1'b0;
    repeat (2) @(posedge clk);
    #5;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
